pong_scoreboard: RTL and testbench

//  Downstream of the pong game FSM. Turns its free-running 4-bit score counters (Ls/Rs) into

---
 rtl/pong_scoreboard_pkg.sv | 28 ++
 rtl/pong_scoreboard_bcd_counter2.sv | 21 ++
 rtl/pong_scoreboard.sv | 77 +++++++
 tb/tb_pong_scoreboard.sv | 132 +++++++++++++
 4 files changed

// File: rtl/pong_scoreboard_pkg.sv
// pong_scoreboard_pkg: shared game codes, digit indices and 7-segment glyphs
package pong_scoreboard_pkg;
  typedef enum logic [1:0] {
    WINNER_NONE  = 2'b00,
    WINNER_LEFT  = 2'b01,
    WINNER_RIGHT = 2'b10,
    WINNER_DRAW  = 2'b11
  } winner_t;
  localparam logic [1:0] DIG_R_UNITS = 2'd0;
  localparam logic [1:0] DIG_R_TENS  = 2'd1;
  localparam logic [1:0] DIG_L_UNITS = 2'd2;
  localparam logic [1:0] DIG_L_TENS  = 2'd3;
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction
endpackage

// File: rtl/pong_scoreboard_bcd_counter2.sv
// bcd_counter2: two-digit BCD counter, saturating at 99
module bcd_counter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] units
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc && !(tens == 4'd9 && units == 4'd9)) begin
      units <= units == 4'd9 ? 4'd0 : units + 4'd1;
      tens  <= units == 4'd9 ? tens + 4'd1 : tens;
    end
endmodule

// File: rtl/pong_scoreboard.sv
// pong_scoreboard: decimal match scores, winner detection and 4-digit muxed 7-seg display
module pong_scoreboard
  import pong_scoreboard_pkg::*;
#(
  parameter int SCAN_BITS  = 16,
  parameter int BLINK_BITS = 24,
  parameter int WIN_SCORE  = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score_l,
  input  logic [3:0] score_r,
  input  logic       clr,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       err
);
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  logic [3:0] prev_l, prev_r, d_l, d_r, tens_l, units_l, tens_r, units_r, val;
  logic [SCAN_BITS+1:0] scan;
  logic [BLINK_BITS:0] blink;
  logic [1:0] sel;
  logic win_l, win_r, off;
  winner_t win_q;
  assign d_l = score_l - prev_l;
  assign d_r = score_r - prev_r;
  assign win_l = {tens_l, units_l} == WIN_BCD;
  assign win_r = {tens_r, units_r} == WIN_BCD;
  assign sel = scan[SCAN_BITS+1 -: 2];
  assign winner = win_q;
  bcd_counter2 u_left (
    .clk(clk), .rst(rst), .clr(clr), .inc(d_l != 4'd0 && !game_over),
    .tens(tens_l), .units(units_l)
  );
  bcd_counter2 u_right (
    .clk(clk), .rst(rst), .clr(clr), .inc(d_r != 4'd0 && !game_over),
    .tens(tens_r), .units(units_r)
  );
  // Left digits blink for a left win, right digits for a right win, all four on a draw
  always_comb begin
    val = sel == DIG_R_UNITS ? units_r : sel == DIG_R_TENS ? tens_r :
          sel == DIG_L_UNITS ? units_l : tens_l;
    off = game_over && !blink[BLINK_BITS] && (sel[1] ? win_q[0] : win_q[1]);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev_l    <= 4'd0;
      prev_r    <= 4'd0;
      scan      <= '0;
      blink     <= '0;
      game_over <= 1'b0;
      win_q     <= WINNER_NONE;
      err       <= 1'b0;
      seg       <= 8'h00;
      an        <= 4'h0;
    end else begin
      prev_l <= score_l;
      prev_r <= score_r;
      scan   <= scan + 1'b1;
      blink  <= blink + 1'b1;
      if (clr) begin
        game_over <= 1'b0;
        win_q     <= WINNER_NONE;
        err       <= 1'b0;
      end else begin
        if (d_l > 4'd1 || d_r > 4'd1) err <= 1'b1;
        if (!game_over && (win_l || win_r)) begin
          game_over <= 1'b1;
          win_q     <= winner_t'({win_r, win_l});
        end
      end
      seg <= off ? 8'h00 : {sel == DIG_L_UNITS, (sel[0] && val == 4'd0) ? 7'h00 : seg7(val)};
      an  <= 4'b0001 << sel;
    end
endmodule

// File: tb/tb_pong_scoreboard.sv
// tb_pong_scoreboard: table-driven check of scoring, win detection, clr and display scan/blink
module tb_pong_scoreboard;
  logic clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic [3:0] score_l = 4'd0, score_r = 4'd0;
  logic [7:0] seg;
  logic [3:0] an;
  logic game_over, err;
  logic [1:0] winner;
  int errors = 0, checks = 0, cyc;
  logic [6:0] gl [10];

  typedef struct {
    logic [3:0] sl, sr;
    logic       c;
    logic       go;
    logic [1:0] win;
    logic       e;
    logic [7:0] l, r;
    string      name;
  } vec_t;
  vec_t v [18];

  pong_scoreboard #(.SCAN_BITS(2), .BLINK_BITS(4), .WIN_SCORE(3)) dut (
    .clk(clk), .rst(rst), .score_l(score_l), .score_r(score_r), .clr(clr),
    .seg(seg), .an(an), .game_over(game_over), .winner(winner), .err(err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst)
    if (!rst) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {an, seg} for the sample taken just after the k-th clock edge since reset release
  function automatic logic [11:0] exp_out(input int k, input logic [7:0] l, input logic [7:0] r,
                                          input logic go, input logic [1:0] w);
    int s, b;
    logic [3:0] d;
    logic [6:0] g;
    logic o;
    s = ((k - 1) >> 2) & 3;
    b = ((k - 1) >> 4) & 1;
    d = s == 0 ? r[3:0] : s == 1 ? r[7:4] : s == 2 ? l[3:0] : l[7:4];
    g = ((s % 2) == 1 && d == 4'd0) ? 7'h00 : gl[d];
    o = go && b == 0 && (s >= 2 ? w[0] : w[1]);
    return {4'b0001 << s, o ? 8'h00 : {s == 2 ? 1'b1 : 1'b0, g}};
  endfunction

  task automatic check_disp(input string name, input logic [7:0] l, input logic [7:0] r,
                            input logic go, input logic [1:0] w);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      chk({name, "_disp"}, {20'h0, an, seg}, {20'h0, exp_out(cyc, l, r, go, w)});
    end
  endtask

  task automatic apply(input vec_t x);
    @(posedge clk);
    #1;
    score_l = x.sl;
    score_r = x.sr;
    clr = x.c;
    @(posedge clk);
    #1;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({x.name, "_go_win_err"}, {28'h0, x.go, x.win, x.e}, {28'h0, game_over, winner, err});
    check_disp(x.name, x.l, x.r, x.go, x.win);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    gl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    v[0]  = '{4'd1, 4'd0,  1'b0, 1'b0, 2'b00, 1'b0, 8'h01, 8'h00, "l1"};
    v[1]  = '{4'd2, 4'd0,  1'b0, 1'b0, 2'b00, 1'b0, 8'h02, 8'h00, "l2"};
    v[2]  = '{4'd2, 4'd14, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, "clr_preload"};
    v[3]  = '{4'd2, 4'd15, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 8'h01, "r1"};
    v[4]  = '{4'd2, 4'd0,  1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 8'h02, "r2_wrap"};
    v[5]  = '{4'd2, 4'd1,  1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 8'h03, "r_wins"};
    v[6]  = '{4'd3, 4'd1,  1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 8'h03, "frozen"};
    v[7]  = '{4'd3, 4'd1,  1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, "clr_new"};
    v[8]  = '{4'd4, 4'd2,  1'b0, 1'b0, 2'b00, 1'b0, 8'h01, 8'h01, "both1"};
    v[9]  = '{4'd5, 4'd3,  1'b0, 1'b0, 2'b00, 1'b0, 8'h02, 8'h02, "both2"};
    v[10] = '{4'd6, 4'd4,  1'b0, 1'b1, 2'b11, 1'b0, 8'h03, 8'h03, "draw"};
    v[11] = '{4'd0, 4'd0,  1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, "clr_draw"};
    v[12] = '{4'd5, 4'd0,  1'b0, 1'b0, 2'b00, 1'b1, 8'h01, 8'h00, "jump"};
    v[13] = '{4'd5, 4'd1,  1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, "clr_drop"};
    v[14] = '{4'd5, 4'd1,  1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 8'h00, "hold"};
    v[15] = '{4'd5, 4'd2,  1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 8'h01, "r1b"};
    v[16] = '{4'd5, 4'd3,  1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 8'h02, "r2b"};
    v[17] = '{4'd5, 4'd4,  1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 8'h03, "r_wins_b"};
    #12;
    chk("reset_outputs", {17'h0, seg, an, game_over, winner, err}, 32'h0);
    #10;
    rst = 1'b1;
    check_disp("idle", 8'h00, 8'h00, 1'b0, 2'b00);
    for (int i = 0; i < 18; i++) apply(v[i]);
    for (int i = 0; i < 40 && cyc[4] != 1'b0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("blink_phase_reached", {31'h0, cyc[4]}, 32'h0);
    rst = 1'b0;
    score_l = 4'd0;
    score_r = 4'd0;
    #1;
    chk("async_reset", {17'h0, seg, an, game_over, winner, err}, 32'h0);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("after_reset_go_win_err", {28'h0, game_over, winner, err}, 32'h0);
    check_disp("after_reset", 8'h00, 8'h00, 1'b0, 2'b00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
